// File: rtl/fb_pkg.sv
// Shared frame-buffer constants, grant-state encoding and address helper
// used by the arbiter, its bus interface and the write FIFO.
package fb_pkg;

    localparam int FB_ADDR_W = 14;
    localparam int FB_BYTES  = 9600;   // 320x240 at 1 bpp
    localparam int MAX_X     = 320;
    localparam int MAX_Y     = 240;
    localparam int FB_FIFO_W = 9;      // {sof, data}

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        G_IDLE = 2'd0,
        G_RD   = 2'd1,
        G_WR   = 2'd2
    } grant_state_t;

    // Next sequential frame-buffer address, wrapping after the last byte.
    function automatic fb_addr_t fb_next_addr(input fb_addr_t addr, input fb_addr_t last_addr);
        return (addr == last_addr) ? '0 : addr + fb_addr_t'(1);
    endfunction

endpackage

// File: rtl/fb_arbiter_if.sv
// Pixel-read, serial-write and single-port RAM signals of the frame-buffer
// arbiter. The slave modport is the arbiter; master is its environment.
interface fb_arbiter_if;
    import fb_pkg::*;

    logic       video_on;
    fb_addr_t   rd_addr;
    logic [7:0] rd_data;
    logic [7:0] wr_data;
    logic       wr_sof;
    logic       wr_valid;
    logic       wr_ready;
    fb_addr_t   ram_addr;
    logic       ram_we;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;
    fb_addr_t   wr_ptr;
    logic       frame_done;

    modport master (
        output video_on, rd_addr, wr_data, wr_sof, wr_valid, ram_rdata,
        input  rd_data, wr_ready, ram_addr, ram_we, ram_wdata, wr_ptr, frame_done
    );

    modport slave (
        input  video_on, rd_addr, wr_data, wr_sof, wr_valid, ram_rdata,
        output rd_data, wr_ready, ram_addr, ram_we, ram_wdata, wr_ptr, frame_done
    );

endinterface

// File: rtl/fb_wr_fifo.sv
// Small write buffer between the serial receiver and the RAM port.
// Entries are {sof, data}; the head is visible combinationally so the
// arbiter can register it into the RAM write data on the pop cycle.
module fb_wr_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        push,
    input  logic [fb_pkg::FB_FIFO_W-1:0] din,
    input  logic                        pop,
    output logic [fb_pkg::FB_FIFO_W-1:0] dout,
    output logic                        full,
    output logic                        empty
);
    import fb_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [FB_FIFO_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]     wr_idx_reg;
    logic [PTR_W-1:0]     rd_idx_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 do_push;
    logic                 do_pop;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_idx_reg];

    // Storage array: no reset so it maps onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; simultaneous push/pop leaves count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_idx_reg <= '0;
            rd_idx_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_idx_reg <= wr_idx_reg + 1'b1;
            end
            if (do_pop) begin
                rd_idx_reg <= rd_idx_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM port arbiter: the pixel reader owns the single-port RAM
// during active video, buffered serial bytes are written during blanking.
// Optional feature macro: FB_STEAL_EN -- when defined, a write may take the
// port during active video whenever the reader repeats its last address.
module fb_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int FB_BYTES   = fb_pkg::FB_BYTES
) (
    input logic          clk,
    input logic          reset_n,
    fb_arbiter_if.slave  bus
);
    import fb_pkg::*;

    localparam fb_addr_t LAST_ADDR = fb_addr_t'(FB_BYTES - 1);

    grant_state_t          state_reg;
    grant_state_t          state_next;
    fb_addr_t              ram_addr_reg;
    fb_addr_t              ram_addr_next;
    logic                  ram_we_reg;
    logic                  ram_we_next;
    logic [7:0]            ram_wdata_reg;
    logic [7:0]            ram_wdata_next;
    logic [7:0]            rd_data_reg;
    fb_addr_t              wr_ptr_reg;
    fb_addr_t              wr_ptr_next;
    logic                  frame_done_reg;
    logic                  frame_done_next;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FB_FIFO_W-1:0]  fifo_head;
    logic                  steal;

    assign fifo_push = bus.wr_valid && !fifo_full;

    fb_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .din     ({bus.wr_sof, bus.wr_data}),
        .pop     (fifo_pop),
        .dout    (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef FB_STEAL_EN
    fb_addr_t prev_rd_addr_reg;
    logic     prev_rd_valid_reg;

    // A repeated read address returns the byte already held in rd_data,
    // so that cycle can be lent to a pending write.
    assign steal = prev_rd_valid_reg && (bus.rd_addr == prev_rd_addr_reg) && !fifo_empty;

    // Remember the address of the most recent read grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_rd_addr_reg  <= '0;
            prev_rd_valid_reg <= 1'b0;
        end else if (state_next == G_RD) begin
            prev_rd_addr_reg  <= bus.rd_addr;
            prev_rd_valid_reg <= 1'b1;
        end
    end
`else
    assign steal = 1'b0;
`endif

    // Grant decision for the coming cycle and the RAM command it issues.
    always_comb begin
        state_next      = G_IDLE;
        ram_addr_next   = ram_addr_reg;
        ram_we_next     = 1'b0;
        ram_wdata_next  = ram_wdata_reg;
        wr_ptr_next     = wr_ptr_reg;
        frame_done_next = 1'b0;
        fifo_pop        = 1'b0;
        if (bus.video_on && !steal) begin
            state_next    = G_RD;
            ram_addr_next = bus.rd_addr;
        end else if (!fifo_empty) begin
            state_next     = G_WR;
            fifo_pop       = 1'b1;
            ram_we_next    = 1'b1;
            ram_wdata_next = fifo_head[7:0];
            if (fifo_head[8]) begin
                // Start of frame re-anchors the write pointer at byte 0.
                ram_addr_next = '0;
                wr_ptr_next   = fb_addr_t'(1);
            end else begin
                ram_addr_next   = wr_ptr_reg;
                wr_ptr_next     = fb_next_addr(wr_ptr_reg, LAST_ADDR);
                frame_done_next = (wr_ptr_reg == LAST_ADDR);
            end
        end
    end

    // Grant state, registered RAM command, write pointer and read-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= G_IDLE;
            ram_addr_reg   <= '0;
            ram_we_reg     <= 1'b0;
            ram_wdata_reg  <= '0;
            rd_data_reg    <= '0;
            wr_ptr_reg     <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            ram_addr_reg   <= ram_addr_next;
            ram_we_reg     <= ram_we_next;
            ram_wdata_reg  <= ram_wdata_next;
            wr_ptr_reg     <= wr_ptr_next;
            frame_done_reg <= frame_done_next;
            // RAM data belongs to the reader only in the cycle after a read grant.
            if (state_reg == G_RD) begin
                rd_data_reg <= bus.ram_rdata;
            end
        end
    end

    assign bus.wr_ready   = !fifo_full;
    assign bus.ram_addr   = ram_addr_reg;
    assign bus.ram_we     = ram_we_reg;
    assign bus.ram_wdata  = ram_wdata_reg;
    assign bus.rd_data    = rd_data_reg;
    assign bus.wr_ptr     = wr_ptr_reg;
    assign bus.frame_done = frame_done_reg;

endmodule

// File: tb/tb_fb_arbiter.sv
// Self-checking bench for fb_arbiter: scoreboard of expected RAM writes and
// read data, one task per scenario, one line printed per transaction.
module tb_fb_arbiter;
    import fb_pkg::*;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    fb_arbiter_if bus ();

    fb_arbiter #(
        .FIFO_DEPTH (4),
        .FB_BYTES   (FB_BYTES)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM contents seen by the reader: a fixed pattern, 0x5A at 0x0123.
    function automatic logic [7:0] ram_pat(input logic [13:0] a);
        if (a == 14'h0123) return 8'h5A;
        return a[7:0] ^ {a[13:8], 2'b01};
    endfunction

    assign bus.ram_rdata = ram_pat(bus.ram_addr);

    typedef struct packed {
        logic [13:0] addr;
        logic [7:0]  data;
    } wr_exp_t;

    wr_exp_t     wr_q[$];
    logic [7:0]  rd_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          fd_count = 0;
    int          wr_count = 0;
    logic [13:0] exp_ptr  = '0;

    // Advance to the next falling edge and score any RAM write issued.
    task automatic tick();
        wr_exp_t e;
        @(negedge clk);
        if (bus.frame_done === 1'b1) fd_count++;
        if (bus.ram_we === 1'b1) begin
            wr_count++;
            n_checks++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0d data=0x%02h, required no write", bus.ram_addr, bus.ram_wdata);
            end else begin
                e = wr_q.pop_front();
                if (bus.ram_addr !== e.addr || bus.ram_wdata !== e.data) begin
                    n_fail++;
                    $display("FAIL ram_write: got addr=%0d data=0x%02h, required addr=%0d data=0x%02h",
                             bus.ram_addr, bus.ram_wdata, e.addr, e.data);
                end else begin
                    $display("write addr=%0d data=0x%02h", bus.ram_addr, bus.ram_wdata);
                end
            end
        end
    endtask

    // Offer one byte for a cycle; on acceptance queue the write it must cause.
    task automatic push_byte(input logic [7:0] d, input logic sof, output logic acc);
        wr_exp_t e;
        tick();
        bus.wr_data  = d;
        bus.wr_sof   = sof;
        bus.wr_valid = 1'b1;
        #1;
        acc = bus.wr_ready;
        if (acc === 1'b1) begin
            if (sof) begin
                e.addr  = 14'd0;
                exp_ptr = 14'd1;
            end else begin
                e.addr  = exp_ptr;
                exp_ptr = (exp_ptr == 14'(FB_BYTES - 1)) ? 14'd0 : exp_ptr + 14'd1;
            end
            e.data = d;
            wr_q.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.wr_valid = 1'b0;
        bus.wr_sof   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.ram_we !== 1'b0)      begin n_fail++; $display("FAIL rst_ram_we: got %b, required 0", bus.ram_we); end
        n_checks++; if (bus.ram_addr !== 14'd0)   begin n_fail++; $display("FAIL rst_ram_addr: got %0d, required 0", bus.ram_addr); end
        n_checks++; if (bus.ram_wdata !== 8'd0)   begin n_fail++; $display("FAIL rst_ram_wdata: got 0x%02h, required 0x00", bus.ram_wdata); end
        n_checks++; if (bus.rd_data !== 8'd0)     begin n_fail++; $display("FAIL rst_rd_data: got 0x%02h, required 0x00", bus.rd_data); end
        n_checks++; if (bus.wr_ptr !== 14'd0)     begin n_fail++; $display("FAIL rst_wr_ptr: got %0d, required 0", bus.wr_ptr); end
        n_checks++; if (bus.frame_done !== 1'b0)  begin n_fail++; $display("FAIL rst_frame_done: got %b, required 0", bus.frame_done); end
        n_checks++; if (bus.wr_ready !== 1'b1)    begin n_fail++; $display("FAIL rst_wr_ready: got %b, required 1", bus.wr_ready); end
        $display("reset checked");
        reset_n = 1'b1;
    endtask

    task automatic test_blank_write();
        logic acc;
        bus.video_on = 1'b0;
        push_byte(8'hA5, 1'b1, acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL blank_accept: got ready=%b, required 1", acc); end
        tick();
        n_checks++; if (bus.ram_we !== 1'b0) begin n_fail++; $display("FAIL blank_latency: got ram_we=%b one cycle after push, required 0", bus.ram_we); end
        tick();
        n_checks++; if (bus.ram_we !== 1'b1)     begin n_fail++; $display("FAIL blank_we: got %b, required 1", bus.ram_we); end
        n_checks++; if (bus.ram_addr !== 14'd0)  begin n_fail++; $display("FAIL blank_addr: got %0d, required 0", bus.ram_addr); end
        n_checks++; if (bus.ram_wdata !== 8'hA5) begin n_fail++; $display("FAIL blank_wdata: got 0x%02h, required 0xa5", bus.ram_wdata); end
        n_checks++; if (bus.wr_ptr !== 14'd1)    begin n_fail++; $display("FAIL blank_wr_ptr: got %0d, required 1", bus.wr_ptr); end
    endtask

    task automatic test_active_read();
        int         w0;
        logic [7:0] exp;
        logic [13:0] a;
        w0 = wr_count;
        tick();
        bus.video_on = 1'b1;
        bus.rd_addr  = 14'h0123;
        tick();
        n_checks++; if (bus.ram_addr !== 14'h0123) begin n_fail++; $display("FAIL read_ram_addr: got 0x%04h, required 0x0123", bus.ram_addr); end
        n_checks++; if (bus.ram_we !== 1'b0)       begin n_fail++; $display("FAIL read_ram_we: got %b, required 0", bus.ram_we); end
        tick();
        n_checks++; if (bus.rd_data !== 8'h5A)     begin n_fail++; $display("FAIL read_rd_data: got 0x%02h, required 0x5a", bus.rd_data); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i >= 2) begin
                exp = rd_q.pop_front();
                n_checks++;
                if (bus.rd_data !== exp) begin
                    n_fail++;
                    $display("FAIL read_stream: got 0x%02h, required 0x%02h", bus.rd_data, exp);
                end else begin
                    $display("read data=0x%02h", bus.rd_data);
                end
            end
            if (i < 8) begin
                a = 14'(100 + i * 37);
                bus.rd_addr = a;
                rd_q.push_back(ram_pat(a));
            end
        end
        n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL read_no_write: got %0d writes, required 0", wr_count - w0); end
    endtask

    task automatic test_back_pressure();
        logic acc;
        logic exp_acc;
        bus.video_on = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.rd_addr = 14'(200 + i);
            push_byte(8'(8'h10 + i), 1'b0, acc);
            exp_acc = (i < 4);
            n_checks++;
            if (acc !== exp_acc) begin
                n_fail++;
                $display("FAIL bp_accept%0d: got ready=%b, required %b", i, acc, exp_acc);
            end
            if (i == 3) begin
                n_checks++;
                if (bus.wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got wr_ready=%b, required 0", bus.wr_ready); end
            end
        end
        tick();
        bus.video_on = 1'b0;
        for (int i = 0; i < 20 && wr_q.size() != 0; i++) tick();
        n_checks++; if (wr_q.size() != 0)      begin n_fail++; $display("FAIL bp_drain: got %0d pending writes, required 0", wr_q.size()); end
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_after: got %b, required 1", bus.wr_ready); end
        n_checks++; if (bus.wr_ptr !== exp_ptr) begin n_fail++; $display("FAIL bp_wr_ptr: got %0d, required %0d", bus.wr_ptr, exp_ptr); end
    endtask

    task automatic test_wrap();
        logic acc;
        logic seen;
        int   tries;
        int   fd_start;
        bus.video_on = 1'b0;
        fd_start = fd_count;
        for (int i = 0; i < FB_BYTES; i++) begin
            tries = 0;
            do begin
                push_byte(8'(i), (i == 0), acc);
                tries++;
            end while (acc !== 1'b1 && tries < 8);
        end
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            if (bus.ram_we === 1'b1 && bus.ram_addr === 14'(FB_BYTES - 1)) begin
                seen = 1'b1;
                n_checks++; if (bus.frame_done !== 1'b1) begin n_fail++; $display("FAIL wrap_frame_done: got %b, required 1", bus.frame_done); end
                n_checks++; if (bus.wr_ptr !== 14'd0)    begin n_fail++; $display("FAIL wrap_wr_ptr: got %0d, required 0", bus.wr_ptr); end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("FAIL wrap_last_write: got no write to %0d, required one", FB_BYTES - 1); end
        tick();
        n_checks++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL wrap_pulse_width: got %b, required 0", bus.frame_done); end
        repeat (3) tick();
        n_checks++; if (fd_count - fd_start != 1) begin n_fail++; $display("FAIL wrap_pulse_count: got %0d, required 1", fd_count - fd_start); end
    endtask

    task automatic test_reset_mid();
        logic acc;
        int   w0;
        bus.video_on = 1'b1;
        for (int i = 0; i < 3; i++) push_byte(8'(8'hC0 + i), 1'b0, acc);
        tick();
        bus.video_on = 1'b0;
        tick();
        n_checks++; if (bus.ram_we !== 1'b1) begin n_fail++; $display("FAIL rstmid_write_active: got %b, required 1", bus.ram_we); end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++; if (bus.ram_we !== 1'b0)   begin n_fail++; $display("FAIL rstmid_ram_we: got %b, required 0", bus.ram_we); end
        n_checks++; if (bus.wr_ptr !== 14'd0)  begin n_fail++; $display("FAIL rstmid_wr_ptr: got %0d, required 0", bus.wr_ptr); end
        n_checks++; if (bus.wr_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_wr_ready: got %b, required 1", bus.wr_ready); end
        wr_q.delete();
        exp_ptr = '0;
        w0 = wr_count;
        tick();
        reset_n = 1'b1;
        repeat (10) tick();
        n_checks++; if (wr_count != w0) begin n_fail++; $display("FAIL rstmid_no_write: got %0d writes, required 0", wr_count - w0); end
        $display("reset mid-frame checked");
    endtask

    task automatic test_steal();
        logic acc;
        int   w0;
        int   bad;
        int   exp_w;
        bus.video_on = 1'b1;
        bus.rd_addr  = 14'h0010;
        w0 = wr_count;
        repeat (3) tick();
        push_byte(8'h71, 1'b0, acc);
        push_byte(8'h72, 1'b0, acc);
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            tick();
            if (bus.rd_data !== ram_pat(14'h0010)) bad++;
        end
`ifdef FB_STEAL_EN
        exp_w = 2;
`else
        exp_w = 0;
`endif
        n_checks++; if (bad != 0)             begin n_fail++; $display("FAIL steal_rd_hold: got %0d cycles off 0x%02h, required 0", bad, ram_pat(14'h0010)); end
        n_checks++; if (wr_count - w0 != exp_w) begin n_fail++; $display("FAIL steal_writes: got %0d, required %0d", wr_count - w0, exp_w); end
        bus.video_on = 1'b0;
        for (int i = 0; i < 20 && wr_q.size() != 0; i++) tick();
        n_checks++; if (wr_q.size() != 0)       begin n_fail++; $display("FAIL steal_drain: got %0d pending, required 0", wr_q.size()); end
        n_checks++; if (bus.wr_ptr !== exp_ptr) begin n_fail++; $display("FAIL steal_wr_ptr: got %0d, required %0d", bus.wr_ptr, exp_ptr); end
    endtask

    initial begin
        bus.video_on = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_data  = '0;
        bus.wr_sof   = 1'b0;
        bus.wr_valid = 1'b0;
        test_reset();
        test_blank_write();
        test_active_read();
        test_back_pressure();
        test_wrap();
        test_reset_mid();
        test_steal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/fb_arbiter.md
FB_ARBITER -- requirements
Module: fb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning write-buffer entries (power of 2, 2..16).
REQ-002 SHALL have parameter FB_BYTES, default 9600, meaning frame-buffer size in bytes (320x240 at 1 bpp).
REQ-003 SHALL have these ports; clock and reset are listed first:
- clk  in  1  sole clock; all logic on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- video_on  in  1  display active; the reader owns the RAM port
- rd_addr  in  14  byte address requested by the pixel generator
- rd_data  out  8  byte returned to the pixel generator
- wr_data  in  8  byte from the serial receiver
- wr_sof  in  1  qualifies wr_data as byte 0 of a new frame
- wr_valid  in  1  writer offers a byte
- wr_ready  out  1  arbiter accepts the byte this cycle
- ram_addr  out  14  single-port RAM address
- ram_we  out  1  RAM write enable
- ram_wdata  out  8  RAM write data
- ram_rdata  in  8  RAM read data, one cycle after ram_addr
- wr_ptr  out  14  next frame-buffer write address
- frame_done  out  1  one-cycle pulse when the last byte is written

Function
REQ-004 SHALL accept a byte when wr_valid and wr_ready are both high on a clock edge.
REQ-005 SHALL drive wr_ready as the combinational inverse of write-FIFO full.
REQ-006 SHALL grant the RAM port each cycle via a 3-state grant FSM: G_IDLE, G_RD, G_WR.
REQ-007 SHALL enter G_RD when video_on=1, with ram_addr<=rd_addr and ram_we<=0.
REQ-008 SHALL enter G_WR when video_on=0 and the FIFO is non-empty, popping the head with ram_addr<=wr_ptr, ram_wdata<=head and ram_we<=1.
REQ-009 SHALL enter G_IDLE otherwise, with ram_we<=0 and ram_addr held.
REQ-010 SHALL register all ram_* outputs, giving one cycle of grant latency.
REQ-011 SHALL capture ram_rdata into the rd_data register on the cycle after G_RD and hold rd_data at all other times; rd_addr-to-rd_data latency is 2 cycles.
REQ-012 SHALL, on every G_WR, advance wr_ptr by 1, wrapping from FB_BYTES-1 to 0.
REQ-013 SHALL pulse frame_done for one cycle when that wrap occurs.
REQ-014 SHALL store wr_sof alongside each FIFO entry; popping a wr_sof entry writes to address 0 and sets wr_ptr to 1.
REQ-015 SHALL never write the RAM while video_on=1 unless FB_STEAL_EN is defined.
REQ-016 SHALL, when the FIFO is full, keep wr_ready low; a simultaneous push and pop is impossible in that case because ready is low.
REQ-017 SHALL, when the FIFO is not full, allow push and pop in the same cycle with no change in occupancy.
REQ-018 SHALL compute addresses at 14 bits with no overflow; FB_BYTES-1 fits in 14 bits.

Reset
REQ-019 SHALL, on reset_n=0, asynchronously set: FSM to G_IDLE, ram_we=0, ram_addr=0, ram_wdata=0, rd_data=0, wr_ptr=0, frame_done=0, FIFO empty (so wr_ready=1).
REQ-020 SHALL discard any buffered bytes when reset asserts mid-frame; no partial RAM write may occur after reset_n falls.

Configuration
REQ-021 SHALL, when FB_STEAL_EN is defined, steal write cycles during active video: with video_on=1, if rd_addr equals the previous G_RD address and the FIFO is non-empty, enter G_WR instead of G_RD.
REQ-022 SHALL, during a stolen cycle, hold rd_data unchanged.
REQ-023 SHALL, without FB_STEAL_EN, behave strictly per REQ-007..REQ-009, and the previous-address register SHALL not exist.

Structure
REQ-024 SHALL take FB_ADDR_W=14, FB_BYTES=9600, MAX_X=320, MAX_Y=240 and the grant-state enumeration from shared package fb_pkg.
REQ-025 SHALL implement the write buffer as sub-module fb_wr_fifo (9-bit entries {sof, data}, synchronous, count-based full/empty).

Verification
REQ-026 Blanking write: video_on=0, push 0xA5 with wr_sof=1 -> 2 cycles later ram_we=1, ram_addr=0, ram_wdata=0xA5; wr_ptr=1.
REQ-027 Active read: video_on=1, rd_addr=0x0123, RAM returns 0x5A -> ram_addr=0x0123 after 1 cycle, rd_data=0x5A after 2 cycles, ram_we never 1.
REQ-028 Back-pressure: video_on=1, push 5 bytes into FIFO_DEPTH=4 -> wr_ready=0 after 4th accept; video_on=0 -> 4 writes to consecutive addresses, then wr_ready=1.
REQ-029 Wrap: preload wr_ptr=9599, write one byte -> ram_addr=9599, frame_done high for exactly one cycle, wr_ptr=0.
REQ-030 Reset mid-operation: 3 bytes buffered, reset_n low for 1 cycle -> ram_we=0 immediately, wr_ptr=0, FIFO empty, no further writes.
REQ-031 FB_STEAL_EN: video_on=1, rd_addr held at 0x0010 for 16 cycles, 2 bytes queued -> both written within the window, rd_data constant.
